vote_session_ctrl: RTL and testbench

//   Sequences one voting session for the 4-voter majority classifier.

---
 rtl/vote_session_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Session sequencer for the 4-voter majority classifier: collects one ballot per
// voter per round, tallies into a one-hot result and re-runs tied rounds.
module vote_session_ctrl #(
    parameter int TIMEOUT    = 16,
    parameter int MAX_ROUNDS = 2,
    parameter int RW         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    vote_vld,
    input  logic [3:0]    vote_val,
    output logic          busy,
    output logic          done,
    output logic [2:0]    result,
    output logic [3:0]    ballot,
    output logic [3:0]    voted,
    output logic [RW-1:0] round,
    output logic          timed_out
);

    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(MAX_ROUNDS - 1);

    localparam logic [2:0] RES_FAIL = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_PASS = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_TALLY,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      ballot_q, ballot_d;
    logic [3:0]      voted_q, voted_d;
    logic [RW-1:0]   round_q, round_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timed_out_q, timed_out_d;
    logic [2:0]      result_q, result_d;

    logic [3:0]      accept;
    logic [3:0]      voted_post;
    logic            full_post;
    logic            timer_last;
    logic [2:0]      yes_cnt;
    logic            rerun;
    logic [2:0]      result_code;

    assign accept      = vote_vld & ~voted_q;
    assign voted_post  = voted_q | accept;
    assign full_post   = &voted_post;
    assign timer_last  = (timer_q == TIMER_LAST);
    assign yes_cnt     = 3'(ballot_q[0]) + 3'(ballot_q[1]) + 3'(ballot_q[2]) + 3'(ballot_q[3]);
    assign rerun       = (yes_cnt == 3'd2) && (round_q < ROUND_LAST);
    assign result_code = (yes_cnt <= 3'd1) ? RES_FAIL :
                         (yes_cnt == 3'd2) ? RES_TIE  : RES_PASS;

    // State register; datapath registers share the same synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            ballot_q    <= '0;
            voted_q     <= '0;
            round_q     <= '0;
            timer_q     <= '0;
            timed_out_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            ballot_q    <= ballot_d;
            voted_q     <= voted_d;
            round_q     <= round_d;
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        // NOTE: default every comb output first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (abort)                        state_d = S_IDLE;
                else if (full_post || timer_last) state_d = S_TALLY;
            end
            S_TALLY: begin
                if (abort)      state_d = S_IDLE;
                else if (rerun) state_d = S_COLLECT;
                else            state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ballot_d    = ballot_q;
        voted_d     = voted_q;
        round_d     = round_q;
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
        result_d    = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ballot_d    = '0;
                    voted_d     = '0;
                    round_d     = '0;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_COLLECT: begin
                if (!abort) begin
                    // Only first-time voters update their ballot bit.
                    voted_d  = voted_post;
                    ballot_d = (ballot_q & ~accept) | (vote_val & accept);
                    timer_d  = timer_q + TW'(1);
                    if (timer_last && !full_post) timed_out_d = 1'b1;
                end
            end
            S_TALLY: begin
                if (!abort) begin
                    if (rerun) begin
                        round_d     = round_q + RW'(1);
                        ballot_d    = '0;
                        voted_d     = '0;
                        timer_d     = '0;
                        timed_out_d = 1'b0;
                    end else begin
                        result_d = result_code;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        result    = result_q;
        ballot    = ballot_q;
        voted     = voted_q;
        round     = round_q;
        timed_out = timed_out_q;
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: a MAX_ROUNDS=2 instance plus a
// MAX_ROUNDS=1 instance sharing the same stimulus.
module tb_vote_session_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [3:0] vote_vld, vote_val;

    logic       busy0, done0, timed_out0;
    logic [2:0] result0;
    logic [3:0] ballot0, voted0;
    logic [1:0] round0;

    logic       busy1, done1, timed_out1;
    logic [2:0] result1;
    logic [3:0] ballot1, voted1;
    logic [0:0] round1;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    vote_session_ctrl #(.TIMEOUT(16), .MAX_ROUNDS(2), .RW(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vote_vld(vote_vld), .vote_val(vote_val),
        .busy(busy0), .done(done0), .result(result0), .ballot(ballot0),
        .voted(voted0), .round(round0), .timed_out(timed_out0)
    );

    vote_session_ctrl #(.TIMEOUT(16), .MAX_ROUNDS(1), .RW(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vote_vld(vote_vld), .vote_val(vote_val),
        .busy(busy1), .done(done1), .result(result1), .ballot(ballot1),
        .voted(voted1), .round(round1), .timed_out(timed_out1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done0 && n < max_cyc);
        chk("done_seen", done0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; vote_vld = '0; vote_val = '0;
        step();
        step();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_result", result0, 0);
        chk("rst_ballot", ballot0, 0);
        chk("rst_voted", voted0, 0);
        chk("rst_round", round0, 0);
        chk("rst_tmo", timed_out0, 0);
        rst = 1'b0;

        // 1: unanimous yes on first COLLECT cycle, done on 3rd cycle
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b1111; vote_val = 4'b1111;
        chk("t1_busy", busy0, 1);
        chk("t1_done_c", done0, 0);
        step();
        vote_vld = '0; vote_val = '0;
        chk("t1_voted", voted0, 4'b1111);
        chk("t1_done_t", done0, 0);
        step();
        chk("t1_done", done0, 1);
        chk("t1_result", result0, 3'b001);
        chk("t1_tmo", timed_out0, 0);
        chk("t1_round", round0, 0);
        chk("t1_result1", result1, 3'b001);
        step();
        chk("t1_done_off", done0, 0);
        chk("t1_idle", busy0, 0);
        chk("t1_hold", result0, 3'b001);

        // 2: tie on round 0, pass on round 1
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b1111; vote_val = 4'b0011;
        step();
        vote_vld = '0; vote_val = '0;
        step();
        chk("t2_nodone", done0, 0);
        chk("t2_busy", busy0, 1);
        chk("t2_round", round0, 1);
        chk("t2_voted_clr", voted0, 0);
        chk("t2_ballot_clr", ballot0, 0);
        chk("t2_d1_done", done1, 1);
        chk("t2_d1_tie", result1, 3'b010);
        vote_vld = 4'b1111; vote_val = 4'b0111;
        step();
        vote_vld = '0; vote_val = '0;
        step();
        chk("t2_done", done0, 1);
        chk("t2_result", result0, 3'b001);
        chk("t2_round_f", round0, 1);
        chk("t2_ballot", ballot0, 4'b0111);
        step();

        // 3: only voter0 votes yes, timeout after 16 COLLECT cycles
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b0001; vote_val = 4'b0001;
        step();
        vote_vld = '0; vote_val = '0;
        chk("t3_voted", voted0, 4'b0001);
        wait_done(40, cyc);
        chk("t3_lat", cyc, 16);
        chk("t3_result", result0, 3'b100);
        chk("t3_tmo", timed_out0, 1);
        chk("t3_ballot", ballot0, 4'b0001);
        chk("t3_voted_f", voted0, 4'b0001);
        step();
        chk("t3_tmo_hold", timed_out0, 1);

        // 4: voter2 re-strobes 0 two cycles later; first ballot wins
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b0100; vote_val = 4'b0100;
        step();
        chk("t4_first", ballot0, 4'b0100);
        chk("t4_tmo_clr", timed_out0, 0);
        vote_vld = '0; vote_val = '0;
        step();
        vote_vld = 4'b1111; vote_val = 4'b0000;
        step();
        vote_vld = '0;
        step();
        chk("t4_done", done0, 1);
        chk("t4_ballot", ballot0, 4'b0100);
        chk("t4_result", result0, 3'b100);
        chk("t4_tmo", timed_out0, 0);
        step();

        // 5: MAX_ROUNDS=1 tie is final; start ignored while busy; abort
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b1111; vote_val = 4'b1100;
        step();
        vote_vld = '0; vote_val = '0;
        step();
        chk("t5_d1_done", done1, 1);
        chk("t5_d1_result", result1, 3'b010);
        chk("t5_d0_round", round0, 1);
        chk("t5_d0_nodone", done0, 0);
        vote_vld = 4'b0001; vote_val = 4'b0001;
        step();
        chk("t5_d1_single", done1, 0);
        chk("t5_d0_voted", voted0, 4'b0001);
        vote_vld = '0; vote_val = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_start_ign", voted0, 4'b0001);
        chk("t6_start_rnd", round0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_abort_busy", busy0, 0);
        chk("t6_abort_done", done0, 0);
        chk("t6_abort_res", result0, 3'b100);
        chk("t6_abort_res1", result1, 3'b010);
        step();
        chk("t6_abort_nodone", done0, 0);

        // 6: reset mid-COLLECT clears everything
        start = 1'b1;
        step();
        start = 1'b0; vote_vld = 4'b0011; vote_val = 4'b0011;
        step();
        chk("t6_pre_voted", voted0, 4'b0011);
        rst = 1'b1; vote_vld = '0; vote_val = '0;
        step();
        chk("t6_rst_busy", busy0, 0);
        chk("t6_rst_result", result0, 0);
        chk("t6_rst_ballot", ballot0, 0);
        chk("t6_rst_voted", voted0, 0);
        chk("t6_rst_round", round0, 0);
        chk("t6_rst_res1", result1, 0);
        rst = 1'b0;
        step();
        chk("t6_idle", busy0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
